// File: rtl/tmds_decoder_if.sv
// ---------------------------------------------------------------------------
// tmds_decoder_if
//   Bundles the raw deserializer input and the decoded TMDS channel outputs.
//
//   master : raw word source / decoded-data consumer (drives raw_in, raw_vld)
//   slave  : the decoder itself (drives everything else)
//
//   raw_in[9:0]     raw deserialized word, bit 0 received first
//   raw_vld         raw_in valid strobe
//   dout[7:0]       decoded pixel data
//   c[1:0]          decoded control bits {c1,c0}
//   de              1 = data symbol, 0 = control token
//   dout_vld        dout/c/de/sym_err valid
//   locked          word alignment achieved
//   bit_offset[3:0] current alignment offset, 0..9
//   sym_err         one-cycle pulse on an erroneous data symbol
//   err_cnt[15:0]   saturating symbol error count (0 unless TMDS_ERR_CNT_EN)
// ---------------------------------------------------------------------------
interface tmds_decoder_if;
    logic [9:0]  raw_in;
    logic        raw_vld;
    logic [7:0]  dout;
    logic [1:0]  c;
    logic        de;
    logic        dout_vld;
    logic        locked;
    logic [3:0]  bit_offset;
    logic        sym_err;
    logic [15:0] err_cnt;

    modport master (
        output raw_in, raw_vld,
        input  dout, c, de, dout_vld, locked, bit_offset, sym_err, err_cnt
    );

    modport slave (
        input  raw_in, raw_vld,
        output dout, c, de, dout_vld, locked, bit_offset, sym_err, err_cnt
    );
endinterface

// File: rtl/tmds_decoder.sv
// ---------------------------------------------------------------------------
// tmds_decoder
//   Receive-side decoder for one TMDS channel. Hunts for the 10-bit word
//   boundary using control tokens, decodes symbols to 8-bit data or 2-bit
//   control, and flags data symbols whose bit 8 disagrees with the encoder's
//   XOR/XNOR choice.
//
//   Ports:
//     sys_clk    pixel-rate clock
//     sys_rst_n  asynchronous active-low reset
//     bus        tmds_decoder_if.slave (raw input, decoded outputs, status)
//
//   Optional build macro TMDS_ERR_CNT_EN: when defined, bus.err_cnt counts
//   sym_err pulses (saturating at 0xFFFF, cleared only by reset); otherwise
//   it is tied to 0.
//
//   Pipeline (advances only on raw_vld): stage 1 registers the aligned word,
//   stage 2 registers the decoded outputs. The error count feeding the
//   loss-of-lock decision uses the stage-2 error flag, so the symbol that
//   reaches ERR_MAX is still reported while locked.
// ---------------------------------------------------------------------------
module tmds_decoder #(
    parameter int SEARCH_WIN = 1024,
    parameter int LOCK_CNT   = 16,
    parameter int ERR_WIN    = 4096,
    parameter int ERR_MAX    = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    tmds_decoder_if.slave bus
);

    localparam int SW_W  = $clog2(SEARCH_WIN);
    localparam int CTL_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(ERR_WIN);
    localparam int ERR_W = $clog2(ERR_MAX + 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

    // ---------------- stage 1: word alignment ----------------
    logic [9:0]  r_prev;
    logic [9:0]  r_q;
    logic [19:0] w_cat;
    logic [3:0]  r_offset;

    assign w_cat = {bus.raw_in, r_prev};

    // NOTE: registers are written with <= so every flop samples the
    // pre-edge values of its neighbours, giving true pipeline behaviour.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_prev <= '0;
            r_q    <= '0;
        end else if (bus.raw_vld) begin
            r_prev <= bus.raw_in;
            r_q    <= w_cat[r_offset +: 10];
        end
    end

    // ---------------- token detect and data decode on r_q ----------------
    logic       w_is_ctl;
    logic [1:0] w_ctl_code;
    logic [7:0] w_t;
    logic [7:0] w_d;
    logic [3:0] w_n1;
    logic       w_exp_q8;
    logic       w_bad;

    // NOTE: every always_comb output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_is_ctl   = 1'b1;
        w_ctl_code = 2'b00;
        case (r_q)
            10'h354: w_ctl_code = 2'b00;
            10'h0AB: w_ctl_code = 2'b01;
            10'h154: w_ctl_code = 2'b10;
            10'h2AB: w_ctl_code = 2'b11;
            default: w_is_ctl   = 1'b0;
        endcase

        w_t    = r_q[9] ? ~r_q[7:0] : r_q[7:0];
        w_d    = '0;
        w_d[0] = w_t[0];
        for (int i = 1; i < 8; i++)
            w_d[i] = r_q[8] ? (w_t[i] ^ w_t[i-1]) : ~(w_t[i] ^ w_t[i-1]);

        w_n1 = '0;
        for (int i = 0; i < 8; i++)
            w_n1 = w_n1 + 4'(w_d[i]);

        // The encoder picks XNOR (q8=0) for dense bytes; anything else is a
        // symbol it could never have produced.
        w_exp_q8 = ~((w_n1 > 4'd4) || ((w_n1 == 4'd4) && !w_d[0]));
        w_bad    = !w_is_ctl && (r_q[8] != w_exp_q8);
    end

    // ---------------- alignment FSM ----------------
    state_t           r_state, w_state_nxt;
    logic [SW_W-1:0]  r_srch_cnt, w_srch_nxt;
    logic [CTL_W-1:0] r_ctl_cnt, w_ctl_nxt;
    logic [WIN_W-1:0] r_win_cnt, w_win_nxt;
    logic [ERR_W-1:0] r_err_num, w_err_nxt, w_err_sum;
    logic [3:0]       w_offset_nxt, w_offset_inc;
    logic             r_err_pend;

    assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
    assign w_err_sum    = r_err_num + ERR_W'(r_err_pend);

    always_comb begin
        w_state_nxt  = r_state;
        w_srch_nxt   = r_srch_cnt;
        w_ctl_nxt    = r_ctl_cnt;
        w_win_nxt    = r_win_cnt;
        w_err_nxt    = r_err_num;
        w_offset_nxt = r_offset;
        case (r_state)
            ST_SEARCH: begin
                if (w_is_ctl) begin
                    w_state_nxt = ST_VERIFY;
                    w_ctl_nxt   = CTL_W'(1);
                    w_srch_nxt  = '0;
                end else if (r_srch_cnt == SW_W'(SEARCH_WIN - 1)) begin
                    w_offset_nxt = w_offset_inc;
                    w_srch_nxt   = '0;
                end else begin
                    w_srch_nxt = r_srch_cnt + 1'b1;
                end
            end
            ST_VERIFY: begin
                if (!w_is_ctl) begin
                    w_state_nxt = ST_SEARCH;
                    w_ctl_nxt   = '0;
                    w_srch_nxt  = '0;
                end else if (r_ctl_cnt == CTL_W'(LOCK_CNT - 1)) begin
                    w_state_nxt = ST_LOCKED;
                    w_ctl_nxt   = '0;
                    w_win_nxt   = '0;
                    w_err_nxt   = '0;
                end else begin
                    w_ctl_nxt = r_ctl_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                // Count the pending error first, then test the limit, and
                // only then let the window expiry clear the count.
                if (w_err_sum == ERR_W'(ERR_MAX)) begin
                    w_state_nxt  = ST_SEARCH;
                    w_offset_nxt = w_offset_inc;
                    w_srch_nxt   = '0;
                    w_ctl_nxt    = '0;
                    w_win_nxt    = '0;
                    w_err_nxt    = '0;
                end else if (r_win_cnt == WIN_W'(ERR_WIN - 1)) begin
                    w_win_nxt = '0;
                    w_err_nxt = '0;
                end else begin
                    w_win_nxt = r_win_cnt + 1'b1;
                    w_err_nxt = w_err_sum;
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_SEARCH;
            r_srch_cnt <= '0;
            r_ctl_cnt  <= '0;
            r_win_cnt  <= '0;
            r_err_num  <= '0;
            r_offset   <= '0;
        end else if (bus.raw_vld) begin
            r_state    <= w_state_nxt;
            r_srch_cnt <= w_srch_nxt;
            r_ctl_cnt  <= w_ctl_nxt;
            r_win_cnt  <= w_win_nxt;
            r_err_num  <= w_err_nxt;
            r_offset   <= w_offset_nxt;
        end
    end

    // ---------------- stage 2: qualified outputs ----------------
    // Qualify by the post-update lock state so the word that completes lock
    // is already reported and nothing is reported once lock is dropped.
    logic       w_lock_nxt;
    logic       w_sym_err_nxt;
    logic [7:0] r_dout;
    logic [1:0] r_c;
    logic       r_de;
    logic       r_dout_vld;
    logic       r_sym_err;

    assign w_lock_nxt    = (w_state_nxt == ST_LOCKED);
    assign w_sym_err_nxt = bus.raw_vld && w_lock_nxt && w_bad;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dout     <= '0;
            r_c        <= '0;
            r_de       <= 1'b0;
            r_dout_vld <= 1'b0;
            r_sym_err  <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_dout_vld <= bus.raw_vld && w_lock_nxt;
            r_sym_err  <= w_sym_err_nxt;
            if (bus.raw_vld) begin
                r_err_pend <= w_sym_err_nxt;
                if (!w_lock_nxt) begin
                    r_dout <= '0;
                    r_c    <= '0;
                    r_de   <= 1'b0;
                end else if (w_is_ctl) begin
                    r_dout <= '0;
                    r_c    <= w_ctl_code;
                    r_de   <= 1'b0;
                end else begin
                    r_dout <= w_d;
                    r_de   <= 1'b1;
                end
            end
        end
    end

`ifdef TMDS_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_err_cnt <= '0;
        else if (w_sym_err_nxt && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.dout       = r_dout;
    assign bus.c          = r_c;
    assign bus.de         = r_de;
    assign bus.dout_vld   = r_dout_vld;
    assign bus.sym_err    = r_sym_err;
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.bit_offset = r_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_decoder
//   Self-checking bench for tmds_decoder with default parameters. Symbols are
//   serialised into raw words with a chosen bit skew; every symbol sent pushes
//   its expected decode into a scoreboard queue, popped two valid words later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tmds_decoder;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    tmds_decoder_if bus ();

    tmds_decoder dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum logic [1:0] {K_DATA, K_CTL, K_RAW} kind_t;

    typedef struct {
        kind_t      kind;
        logic [9:0] val;      // byte, token code, or raw symbol
        logic       chk;      // compare this entry at all
        logic       exp_vld;
        logic [7:0] exp_dout;
        logic       exp_de;
        logic [1:0] exp_c;
        logic       exp_err;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         disp   = 0;
    int         skew   = 3;
    logic [9:0] prev_sym = 10'h354;
    vec_t       sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(kind_t k, logic [9:0] val, logic chk, logic ev,
                                logic [7:0] dout, logic de, logic [1:0] c, logic err);
        vec_t v;
        v.kind = k; v.val = val; v.chk = chk; v.exp_vld = ev;
        v.exp_dout = dout; v.exp_de = de; v.exp_c = c; v.exp_err = err;
        return v;
    endfunction

    function automatic logic [9:0] token(input logic [1:0] code);
        logic [9:0] t;
        case (code)
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    // Reference DVI encoder with running disparity.
    task automatic encode(input logic [7:0] d, output logic [9:0] q);
        int   n1d, n1, n0;
        logic use_xnor;
        logic [8:0] qm;
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (disp == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(~qm[8]) + (n1 - n0);
        end
    endtask

    // Send one symbol as one valid raw word, then score the output of the
    // symbol sent two valid words earlier.
    task automatic send(input vec_t v);
        logic [9:0]  sym;
        logic [19:0] cat;
        vec_t        e;
        case (v.kind)
            K_DATA:  encode(v.val[7:0], sym);
            K_CTL:   begin sym = token(v.val[1:0]); disp = 0; end
            default: sym = v.val;
        endcase
        cat = {sym, prev_sym};
        bus.raw_in  = 10'(cat >> (10 - skew));
        bus.raw_vld = 1'b1;
        prev_sym    = sym;
        sb.push_back(v);
        @(posedge sys_clk);
        #1;
        if (sb.size() > 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("sb dout_vld", bus.dout_vld, e.exp_vld);
                if (e.exp_vld) begin
                    check("sb dout", bus.dout, e.exp_dout);
                    check("sb de", bus.de, e.exp_de);
                    check("sb c", bus.c, e.exp_c);
                    check("sb sym_err", bus.sym_err, e.exp_err);
                end
            end
        end
    endtask

    task automatic idle();
        bus.raw_vld = 1'b0;
        bus.raw_in  = 10'($urandom);
        @(posedge sys_clk);
        #1;
        check("stall dout_vld", bus.dout_vld, 0);
        check("stall sym_err", bus.sym_err, 0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        vec_t tbl [11];
        vec_t tok_off;
        vec_t err_a, err_b, good;
        int   k;

        tbl[0]  = mk(K_DATA, 10'h000, 1, 1, 8'h00, 1, 2'b00, 0);
        tbl[1]  = mk(K_DATA, 10'h0FF, 1, 1, 8'hFF, 1, 2'b00, 0);
        tbl[2]  = mk(K_DATA, 10'h05A, 1, 1, 8'h5A, 1, 2'b00, 0);
        tbl[3]  = mk(K_DATA, 10'h0A5, 1, 1, 8'hA5, 1, 2'b00, 0);
        tbl[4]  = mk(K_CTL,  10'h001, 1, 1, 8'h00, 0, 2'b01, 0);
        tbl[5]  = mk(K_DATA, 10'h03C, 1, 1, 8'h3C, 1, 2'b01, 0);
        tbl[6]  = mk(K_CTL,  10'h002, 1, 1, 8'h00, 0, 2'b10, 0);
        tbl[7]  = mk(K_CTL,  10'h003, 1, 1, 8'h00, 0, 2'b11, 0);
        tbl[8]  = mk(K_DATA, 10'h081, 1, 1, 8'h81, 1, 2'b11, 0);
        tbl[9]  = mk(K_CTL,  10'h000, 1, 1, 8'h00, 0, 2'b00, 0);
        tbl[10] = mk(K_DATA, 10'h07E, 1, 1, 8'h7E, 1, 2'b00, 0);

        tok_off = mk(K_CTL, 10'h000, 0, 0, 8'h00, 0, 2'b00, 0);
        // Flipping only bit 8 of a legal symbol yields another self-consistent
        // symbol, so the error words use a chain pattern the encoder never
        // emits: q[7:0] resolves to 0x55 with q8=0, which decodes to 0x01.
        err_a = mk(K_RAW, 10'h055, 1, 1, 8'h01, 1, 2'b00, 1);
        err_b = mk(K_RAW, 10'h2AA, 1, 1, 8'h01, 1, 2'b00, 1);
        good  = mk(K_DATA, 10'h05A, 1, 1, 8'h5A, 1, 2'b00, 0);

        bus.raw_in  = '0;
        bus.raw_vld = 1'b0;
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst locked", bus.locked, 0);
        check("rst dout_vld", bus.dout_vld, 0);
        check("rst bit_offset", bus.bit_offset, 0);
        check("rst dout", bus.dout, 0);
        check("rst c", bus.c, 0);
        check("rst de", bus.de, 0);
        check("rst sym_err", bus.sym_err, 0);
        check("rst err_cnt", bus.err_cnt, 0);
        #20 sys_rst_n = 1'b1;

        // Token stream skewed by 3 bits; word 3082 is data and breaks VERIFY.
        for (int n = 1; n <= 3100; n++) begin
            if (n == 3082) send(mk(K_DATA, 10'h000, 0, 0, 8'h00, 0, 2'b00, 0));
            else           send(tok_off);
            case (n)
                1023: check("offset before 1st step", bus.bit_offset, 0);
                1024: check("offset after 1st step", bus.bit_offset, 1);
                2047: check("offset before 2nd step", bus.bit_offset, 1);
                2048: check("offset after 2nd step", bus.bit_offset, 2);
                3072: check("offset after 3rd step", bus.bit_offset, 3);
                3084: begin
                    check("verify break locked", bus.locked, 0);
                    check("verify break offset", bus.bit_offset, 3);
                end
                3089: check("no lock after break", bus.locked, 0);
                3099: begin
                    check("locked before 16th", bus.locked, 0);
                    check("dout_vld before lock", bus.dout_vld, 0);
                end
                3100: begin
                    check("locked at 16th", bus.locked, 1);
                    check("lock dout_vld", bus.dout_vld, 1);
                    check("lock de", bus.de, 0);
                    check("lock c", bus.c, 0);
                    check("lock dout", bus.dout, 0);
                    check("lock offset", bus.bit_offset, 3);
                end
                default: ;
            endcase
        end

        // Table pass 0 back-to-back, pass 1 with raw_vld toggling.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 11; i++) begin
                send(tbl[i]);
                if (pass == 1) idle();
            end
        end

        // Eight bad symbols inside one error window.
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 1) ? err_b : err_a);
            if (i < 7) send(good);
        end
        check("locked after 8th err sent", bus.locked, 1);
        send(mk(K_CTL, 10'h000, 1, 0, 8'h00, 0, 2'b00, 0));
        send(tok_off);
        check("locked at 8th err pulse", bus.locked, 1);
        send(tok_off);
        check("lock lost", bus.locked, 0);
        check("offset advanced", bus.bit_offset, 4);
`ifdef TMDS_ERR_CNT_EN
        check("err_cnt after errors", bus.err_cnt, 8);
`else
        check("err_cnt tied off", bus.err_cnt, 0);
`endif

        // Re-skew the stream to match offset 4 and wait (bounded) for lock.
        skew = 4;
        k = 0;
        while (!bus.locked && k < 200) begin
            send(tok_off);
            k++;
        end
        check("relock at offset 4", bus.locked, 1);
        check("relock offset", bus.bit_offset, 4);

        // Asynchronous reset mid-cycle while locked.
        #3 sys_rst_n = 1'b0;
        #1;
        check("async rst locked", bus.locked, 0);
        check("async rst dout_vld", bus.dout_vld, 0);
        check("async rst bit_offset", bus.bit_offset, 0);
        check("async rst err_cnt", bus.err_cnt, 0);
        check("async rst c", bus.c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
